// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issue controller between the core and the FPU hub.
// Accepts one FP request at a time, resolves the dynamic rounding mode,
// hands the operation to the hub, waits for its answer and returns the
// result to the core. Flush and reset discard any in-flight hub result.

package fp_issue_pkg;

  typedef enum logic [3:0] {
    FP_ADD   = 4'd0,
    FP_SUB   = 4'd1,
    FP_MUL   = 4'd2,
    FP_DIV   = 4'd3,
    FP_SQRT  = 4'd4,
    FP_FMADD = 4'd5,
    FP_CVT   = 4'd6,
    FP_CMP   = 4'd7
  } fp_operation_type;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_hub_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_hub_out_type;

endpackage

module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_data1_i,
  input  logic [63:0]      req_data2_i,
  input  logic [63:0]      req_data3_i,
  input  fp_operation_type req_op_i,
  input  logic [1:0]       req_fmt_i,
  input  logic [2:0]       req_rm_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             req_wb_int_i,
  input  logic [2:0]       frm_i,
  input  logic             flush_i,
  output fp_hub_in_type    hub_req_o,
  input  fp_hub_out_type   hub_rsp_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [63:0]      rsp_result_o,
  output logic [4:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_wb_int_o,
  output logic             rsp_illegal_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e           state_q,   state_d;
  logic [63:0]      data1_q,   data1_d;
  logic [63:0]      data2_q,   data2_d;
  logic [63:0]      data3_q,   data3_d;
  fp_operation_type op_q,      op_d;
  logic [1:0]       fmt_q,     fmt_d;
  logic [2:0]       rm_q,      rm_d;
  logic [TAG_W-1:0] tag_q,     tag_d;
  logic             wb_int_q,  wb_int_d;
  logic [63:0]      result_q,  result_d;
  logic [4:0]       flags_q,   flags_d;
  logic             illegal_q, illegal_d;

  logic             accept_s;
  logic [2:0]       rm_res_s;
  logic             rm_bad_s;

  // A request is taken only when idle and no flush is pending.
  assign accept_s = (state_q == S_IDLE) && req_valid_i && !flush_i;
  // 3'b111 in the instruction means "use the dynamic mode from fcsr".
  assign rm_res_s = (req_rm_i == 3'b111) ? frm_i : req_rm_i;
  // Modes 5..7 are reserved; such requests never reach the hub.
  assign rm_bad_s = (rm_res_s >= 3'd5);

  // Next-state and datapath-capture logic for the single-outstanding FSM.
  always_comb begin
    state_d   = state_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    data3_d   = data3_q;
    op_d      = op_q;
    fmt_d     = fmt_q;
    rm_d      = rm_q;
    tag_d     = tag_q;
    wb_int_d  = wb_int_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          data1_d  = req_data1_i;
          data2_d  = req_data2_i;
          data3_d  = req_data3_i;
          op_d     = req_op_i;
          fmt_d    = req_fmt_i;
          rm_d     = rm_res_s;
          tag_d    = req_tag_i;
          wb_int_d = req_wb_int_i;
          if (rm_bad_s) begin
            result_d  = 64'd0;
            flags_d   = 5'd0;
            illegal_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            illegal_d = 1'b0;
            state_d   = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      // ISSUE and WAIT both sample the hub answer; a flush discards it.
      S_ISSUE, S_WAIT: begin
        if (hub_rsp_i.ready) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            result_d = hub_rsp_i.result;
            flags_d  = hub_rsp_i.flags;
            state_d  = S_RESP;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        if (flush_i || rsp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end

      // Swallow the answer of the flushed operation before going idle.
      S_DRAIN: begin
        if (hub_rsp_i.ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-field registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data1_q   <= 64'd0;
      data2_q   <= 64'd0;
      data3_q   <= 64'd0;
      op_q      <= FP_ADD;
      fmt_q     <= 2'd0;
      rm_q      <= 3'd0;
      tag_q     <= '0;
      wb_int_q  <= 1'b0;
      result_q  <= 64'd0;
      flags_q   <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      data3_q   <= data3_d;
      op_q      <= op_d;
      fmt_q     <= fmt_d;
      rm_q      <= rm_d;
      tag_q     <= tag_d;
      wb_int_q  <= wb_int_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // Hub request: operand fields come straight from the captured registers,
  // enable is a one-cycle pulse decoded from the ISSUE state.
  always_comb begin
    hub_req_o        = '0;
    hub_req_o.data1  = data1_q;
    hub_req_o.data2  = data2_q;
    hub_req_o.data3  = data3_q;
    hub_req_o.op     = op_q;
    hub_req_o.fmt    = fmt_q;
    hub_req_o.rm     = rm_q;
    hub_req_o.enable = (state_q == S_ISSUE);
  end

  assign req_ready_o   = (state_q == S_IDLE) && !flush_i;
  assign rsp_valid_o   = (state_q == S_RESP);
  assign rsp_result_o  = result_q;
  assign rsp_flags_o   = flags_q;
  assign rsp_tag_o     = tag_q;
  assign rsp_wb_int_o  = wb_int_q;
  assign rsp_illegal_o = illegal_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: a transaction-level model tracks what the
// controller owes the core and the hub, a negedge process compares every
// cycle, and the directed sequence adds hand-computed literal checks.

module tb_fp_issue_ctrl;
  import fp_issue_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [63:0]      req_data1_i = 64'd0;
  logic [63:0]      req_data2_i = 64'd0;
  logic [63:0]      req_data3_i = 64'd0;
  fp_operation_type req_op_i = FP_ADD;
  logic [1:0]       req_fmt_i = 2'd0;
  logic [2:0]       req_rm_i = 3'd0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             req_wb_int_i = 1'b0;
  logic [2:0]       frm_i = 3'd0;
  logic             flush_i = 1'b0;
  fp_hub_in_type    hub_req_o;
  fp_hub_out_type   hub_rsp_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [63:0]      rsp_result_o;
  logic [4:0]       rsp_flags_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_wb_int_o;
  logic             rsp_illegal_o;
  logic             busy_o;

  fp_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data1_i(req_data1_i), .req_data2_i(req_data2_i), .req_data3_i(req_data3_i),
    .req_op_i(req_op_i), .req_fmt_i(req_fmt_i), .req_rm_i(req_rm_i),
    .req_tag_i(req_tag_i), .req_wb_int_i(req_wb_int_i), .frm_i(frm_i),
    .flush_i(flush_i), .hub_req_o(hub_req_o), .hub_rsp_i(hub_rsp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
    .rsp_tag_o(rsp_tag_o), .rsp_wb_int_o(rsp_wb_int_o),
    .rsp_illegal_o(rsp_illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] eff_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == 3'b111) ? frm : rm;
  endfunction

  // ---------------- transaction-level model ----------------
  // m_send: an accepted op must be presented to the hub this cycle
  // m_hub : the hub owns an op and its answer is still outstanding
  // m_drop: that outstanding answer belongs to a flushed op
  // m_rsp : a response is owed to the core
  logic             m_send = 1'b0, m_hub = 1'b0, m_drop = 1'b0, m_rsp = 1'b0;
  logic [63:0]      m_d1 = 64'd0, m_d2 = 64'd0, m_d3 = 64'd0;
  logic [3:0]       m_op = 4'd0;
  logic [1:0]       m_fmt = 2'd0;
  logic [2:0]       m_rm = 3'd0;
  logic [63:0]      m_res = 64'd0;
  logic [4:0]       m_flg = 5'd0;
  logic [TAG_W-1:0] m_tag = '0;
  logic             m_wb = 1'b0, m_ill = 1'b0;

  // Advance the model on each clock edge from the inputs seen at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_send <= 1'b0; m_hub <= 1'b0; m_drop <= 1'b0; m_rsp <= 1'b0;
      m_res <= 64'd0; m_flg <= 5'd0; m_tag <= '0; m_wb <= 1'b0; m_ill <= 1'b0;
    end else if (m_rsp) begin
      if (flush_i || rsp_ready_i) m_rsp <= 1'b0;
    end else if (m_send || m_hub) begin
      if (hub_rsp_i.ready) begin
        m_send <= 1'b0; m_hub <= 1'b0; m_drop <= 1'b0;
        if (!(m_drop || flush_i)) begin
          m_rsp <= 1'b1; m_res <= hub_rsp_i.result; m_flg <= hub_rsp_i.flags; m_ill <= 1'b0;
        end
      end else begin
        m_send <= 1'b0; m_hub <= 1'b1; m_drop <= m_drop || flush_i;
      end
    end else if (req_valid_i && !flush_i) begin
      m_tag <= req_tag_i; m_wb <= req_wb_int_i;
      if (eff_rm(req_rm_i, frm_i) > 3'd4) begin
        m_rsp <= 1'b1; m_res <= 64'd0; m_flg <= 5'd0; m_ill <= 1'b1;
      end else begin
        m_send <= 1'b1;
        m_d1 <= req_data1_i; m_d2 <= req_data2_i; m_d3 <= req_data3_i;
        m_op <= req_op_i; m_fmt <= req_fmt_i; m_rm <= eff_rm(req_rm_i, frm_i);
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_enable", 64'(hub_req_o.enable), 64'd0);
      check("rst_hub_data1", hub_req_o.data1, 64'd0);
      check("rst_hub_data2", hub_req_o.data2, 64'd0);
      check("rst_hub_data3", hub_req_o.data3, 64'd0);
      check("rst_hub_ctl", 64'({hub_req_o.op, hub_req_o.fmt, hub_req_o.rm}), 64'd0);
      check("rst_rsp_result", rsp_result_o, 64'd0);
      check("rst_rsp_misc", 64'({rsp_flags_o, rsp_tag_o, rsp_wb_int_o, rsp_illegal_o}), 64'd0);
    end else begin
      check("busy", 64'(busy_o), 64'(m_send | m_hub | m_rsp));
      check("req_ready", 64'(req_ready_o), 64'(!(m_send | m_hub | m_rsp) && !flush_i));
      check("hub_enable", 64'(hub_req_o.enable), 64'(m_send));
      check("rsp_valid", 64'(rsp_valid_o), 64'(m_rsp));
      if (m_send || m_hub) begin
        check("hub_data1", hub_req_o.data1, m_d1);
        check("hub_data2", hub_req_o.data2, m_d2);
        check("hub_data3", hub_req_o.data3, m_d3);
        check("hub_op", 64'(hub_req_o.op), 64'(m_op));
        check("hub_fmt", 64'(hub_req_o.fmt), 64'(m_fmt));
        check("hub_rm", 64'(hub_req_o.rm), 64'(m_rm));
      end
      if (m_rsp) begin
        check("rsp_result", rsp_result_o, m_res);
        check("rsp_flags", 64'(rsp_flags_o), 64'(m_flg));
        check("rsp_tag", 64'(rsp_tag_o), 64'(m_tag));
        check("rsp_wb_int", 64'(rsp_wb_int_o), 64'(m_wb));
        check("rsp_illegal", 64'(rsp_illegal_o), 64'(m_ill));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input fp_operation_type op, input logic [2:0] rm,
                      input logic [TAG_W-1:0] tag, input logic wb, input logic [63:0] d1);
    req_valid_i  = 1'b1;
    req_op_i     = op;
    req_rm_i     = rm;
    req_tag_i    = tag;
    req_wb_int_i = wb;
    req_fmt_i    = 2'd1;
    req_data1_i  = d1;
    req_data2_i  = ~d1;
    req_data3_i  = d1 ^ 64'h0F0F_0F0F_0F0F_0F0F;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("lit_rst_busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("lit_ready_after_rst", 64'(req_ready_o), 64'd1);

    // Single-cycle fadd, hub ready in the enable cycle
    step();
    send(FP_ADD, 3'd0, 5'd3, 1'b0, 64'h3FF0_0000_0000_0000);
    @(negedge clk);
    check("lit_t1_ready", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    hub_rsp_i = '{result: 64'h4000_0000_0000_0000, flags: 5'b00001, ready: 1'b1};
    @(negedge clk);
    check("lit_t1_enable", 64'(hub_req_o.enable), 64'd1);
    check("lit_t1_rsp_early", 64'(rsp_valid_o), 64'd0);
    step();
    hub_rsp_i.ready = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("lit_t1_valid", 64'(rsp_valid_o), 64'd1);
    check("lit_t1_enable_off", 64'(hub_req_o.enable), 64'd0);
    check("lit_t1_result", rsp_result_o, 64'h4000_0000_0000_0000);
    check("lit_t1_flags", 64'(rsp_flags_o), 64'd1);
    check("lit_t1_tag", 64'(rsp_tag_o), 64'd3);
    check("lit_t1_illegal", 64'(rsp_illegal_o), 64'd0);
    check("lit_t1_no_accept", 64'(req_ready_o), 64'd0);
    step();
    rsp_ready_i = 1'b0;
    @(negedge clk);
    check("lit_t1_idle", 64'(busy_o), 64'd0);

    // Multi-cycle fdiv: hub ready 20 cycles after enable, 3 cycles backpressure
    step();
    send(FP_DIV, 3'd1, 5'd9, 1'b1, 64'h4024_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step();
      @(negedge clk);
      check("lit_t2_data1_hold", hub_req_o.data1, 64'h4024_0000_0000_0000);
      check("lit_t2_not_ready", 64'(req_ready_o), 64'd0);
      check("lit_t2_no_enable", 64'(hub_req_o.enable), 64'd0);
    end
    step();
    hub_rsp_i = '{result: 64'h3FF8_0000_0000_0000, flags: 5'b00001, ready: 1'b1};
    step();
    hub_rsp_i.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_t2_hold_valid", 64'(rsp_valid_o), 64'd1);
      check("lit_t2_hold_result", rsp_result_o, 64'h3FF8_0000_0000_0000);
      check("lit_t2_hold_tag", 64'(rsp_tag_o), 64'd9);
      check("lit_t2_hold_wb", 64'(rsp_wb_int_o), 64'd1);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    @(negedge clk);
    check("lit_t2_idle", 64'(busy_o), 64'd0);

    // Dynamic rounding mode resolves to frm_i
    step();
    frm_i = 3'd2;
    send(FP_MUL, 3'd7, 5'd4, 1'b0, 64'h4008_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    hub_rsp_i = '{result: 64'h4018_0000_0000_0000, flags: 5'b00000, ready: 1'b1};
    @(negedge clk);
    check("lit_t3_rm_dyn", 64'(hub_req_o.rm), 64'd2);
    step();
    hub_rsp_i.ready = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // Dynamic mode resolving to a reserved value: no hub traffic
    frm_i = 3'd5;
    send(FP_SUB, 3'd7, 5'd6, 1'b1, 64'h1234_5678_9ABC_DEF0);
    step();
    req_valid_i = 1'b0;
    @(negedge clk);
    check("lit_t3_ill_enable", 64'(hub_req_o.enable), 64'd0);
    check("lit_t3_ill_valid", 64'(rsp_valid_o), 64'd1);
    check("lit_t3_ill_flag", 64'(rsp_illegal_o), 64'd1);
    check("lit_t3_ill_result", rsp_result_o, 64'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    frm_i = 3'd0;

    // Flush in WAIT, hub answers 5 cycles later
    send(FP_SQRT, 3'd0, 5'd12, 1'b0, 64'h4010_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_t4_drain_busy", 64'(busy_o), 64'd1);
      check("lit_t4_drain_novalid", 64'(rsp_valid_o), 64'd0);
      step();
    end
    hub_rsp_i = '{result: 64'h4000_0000_0000_0000, flags: 5'b00000, ready: 1'b1};
    @(negedge clk);
    check("lit_t4_drain_last", 64'(busy_o), 64'd1);
    step();
    hub_rsp_i.ready = 1'b0;
    @(negedge clk);
    check("lit_t4_idle", 64'(busy_o), 64'd0);
    check("lit_t4_novalid", 64'(rsp_valid_o), 64'd0);
    step();
    send(FP_ADD, 3'd3, 5'd1, 1'b0, 64'h4000_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    hub_rsp_i = '{result: 64'h4010_0000_0000_0000, flags: 5'b00000, ready: 1'b1};
    @(negedge clk);
    check("lit_t4_next_enable", 64'(hub_req_o.enable), 64'd1);
    check("lit_t4_next_rm", 64'(hub_req_o.rm), 64'd3);
    step();
    hub_rsp_i.ready = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("lit_t4_next_result", rsp_result_o, 64'h4010_0000_0000_0000);
    check("lit_t4_next_tag", 64'(rsp_tag_o), 64'd1);
    step();
    rsp_ready_i = 1'b0;

    // Flush in RESP drops the response
    send(FP_MUL, 3'd2, 5'd7, 1'b0, 64'h4020_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    hub_rsp_i = '{result: 64'h4040_0000_0000_0000, flags: 5'b00010, ready: 1'b1};
    step();
    hub_rsp_i.ready = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    check("lit_t5_valid_before_flush", 64'(rsp_valid_o), 64'd1);
    step();
    flush_i = 1'b0;
    @(negedge clk);
    check("lit_t5_dropped", 64'(rsp_valid_o), 64'd0);
    check("lit_t5_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset while in WAIT, then a late hub answer
    step();
    send(FP_DIV, 3'd0, 5'd2, 1'b1, 64'h4050_0000_0000_0000);
    step();
    req_valid_i = 1'b0;
    step();
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("lit_t5_rst_busy", 64'(busy_o), 64'd0);
    check("lit_t5_rst_data1", hub_req_o.data1, 64'd0);
    check("lit_t5_rst_tag", 64'(rsp_tag_o), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("lit_t5_ready", 64'(req_ready_o), 64'd1);
    step();
    hub_rsp_i = '{result: 64'h7FF8_0000_0000_0000, flags: 5'b10000, ready: 1'b1};
    step();
    hub_rsp_i.ready = 1'b0;
    @(negedge clk);
    check("lit_t5_late_novalid", 64'(rsp_valid_o), 64'd0);
    check("lit_t5_late_idle", 64'(busy_o), 64'd0);

    // Flush while idle blocks acceptance
    step();
    send(FP_ADD, 3'd0, 5'd5, 1'b0, 64'h1);
    flush_i = 1'b1;
    @(negedge clk);
    check("lit_t6_flush_ready", 64'(req_ready_o), 64'd0);
    step();
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("lit_t6_not_taken", 64'(busy_o), 64'd0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning the width of the destination tag carried from request to response.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have ports: rst  in  1  reset; asynchronous and active-high.
REQ-004 SHALL have ports: req_valid_i  in  1  core request valid; req_ready_o  out  1  request accepted when both are high.
REQ-005 SHALL have ports: req_data1_i / req_data2_i / req_data3_i  in  64 each  operands.
REQ-006 SHALL have ports: req_op_i  in  fp_operation_type  decoded operation.
REQ-007 SHALL have ports: req_fmt_i  in  2  format; req_rm_i  in  3  instruction rounding mode.
REQ-008 SHALL have ports: req_tag_i  in  TAG_W  destination tag; req_wb_int_i  in  1  result targets integer file.
REQ-009 SHALL have ports: frm_i  in  3  dynamic rounding mode from fcsr.
REQ-010 SHALL have ports: flush_i  in  1  pipeline flush.
REQ-011 SHALL have ports: hub_req_o  out  fp_hub_in_type  FPU hub request; hub_rsp_i  in  fp_hub_out_type  FPU hub response.
REQ-012 SHALL have ports: rsp_valid_o  out  1 and rsp_ready_i  in  1  response handshake.
REQ-013 SHALL have ports: rsp_result_o  out  64; rsp_flags_o  out  5; rsp_tag_o  out  TAG_W; rsp_wb_int_o  out  1.
REQ-014 SHALL have ports: rsp_illegal_o  out  1  illegal rounding mode; busy_o  out  1  state not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, DRAIN; single outstanding operation.
REQ-016 req_ready_o SHALL be 1 only in IDLE with flush_i=0.
REQ-017 On acceptance: register operands, op, fmt, tag, wb_int; resolved rm = (req_rm_i==3'b111) ? frm_i : req_rm_i.
REQ-018 If resolved rm is 5, 6 or 7: skip the hub and go to RESP with result 0, flags 0, rsp_illegal_o=1.
REQ-019 Otherwise the FSM SHALL go to ISSUE.
REQ-020 ISSUE: hub_req_o.enable=1 for exactly one cycle, then go to WAIT; enable SHALL be 0 in all other states.
REQ-021 hub_req_o data1/2/3, op, fmt and rm SHALL hold the registered values from ISSUE until hub_rsp_i.ready is sampled.
REQ-022 hub_rsp_i.ready SHALL be sampled in ISSUE and WAIT; when it is 1, capture result and flags and go to RESP.
REQ-023 Minimum latency: accept at cycle N, enable at N+1, rsp_valid_o at N+2 when the hub returns ready in the enable cycle.
REQ-024 No timeout: WAIT SHALL hold indefinitely until ready.
REQ-025 RESP: rsp_valid_o=1; all rsp_* outputs stable until rsp_ready_i=1, then go to IDLE.
REQ-026 No new request is accepted in the cycle the response is consumed (IDLE is re-entered first).
REQ-027 hub_rsp_i.ready in IDLE, RESP or DRAIN-exit cycles outside the expected window SHALL be ignored.
REQ-028 flush_i in ISSUE (enable still driven that cycle) or WAIT: go to DRAIN, or straight to IDLE if ready is high that cycle; the result SHALL be discarded.
REQ-029 DRAIN: wait for hub_rsp_i.ready, discard it, then go to IDLE; rsp_valid_o=0 throughout.
REQ-030 flush_i in RESP: drop the response and go to IDLE.
REQ-031 flush_i in IDLE: no acceptance.
REQ-032 flush_i in DRAIN: no effect.
REQ-033 rsp_illegal_o SHALL be 0 for every hub-executed operation.
REQ-034 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE and all registered fields=0.
REQ-036 Outputs during and after reset: hub_req_o all 0, rsp_valid_o=0, rsp_* outputs 0, busy_o=0, req_ready_o=1 once rst=0.
REQ-037 Reset mid-operation SHALL abandon any hub result; a hub ready arriving after reset is ignored per REQ-027.

Verification
REQ-038 Single-cycle op: fadd, rm=0, tag=3, hub ready in the enable cycle.
- Required: enable high 1 cycle; rsp_valid at N+2; result/flags equal the hub values; tag=3; rsp_illegal_o=0.
REQ-039 Multi-cycle op with backpressure: fdiv, hub ready 20 cycles after enable, rsp_ready_i low for 3 cycles.
- Required: data fields stable for 20 cycles; rsp outputs held 3 cycles; req_ready_o=0 until return to IDLE.
REQ-040 Dynamic rounding: req_rm_i=7, frm_i=2.
- Required: hub_req_o.rm=2.
- Also: with frm_i=5 -> no enable, rsp_valid_o=1, rsp_illegal_o=1, result 0.
REQ-041 Flush in WAIT: assert flush_i, hub ready 5 cycles later.
- Required: DRAIN for 5 cycles; no rsp_valid_o; IDLE afterwards; next request issues normally.
REQ-042 Flush in RESP, then async reset in WAIT.
- Required: response dropped; after reset all outputs 0 and busy_o=0; a late hub ready produces no response.
